// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, control FSM states
// and the helper that classifies iterative (multiply/divide) opcodes.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_EQ   = 4'd4,
        ALU_NE   = 4'd5,
        ALU_LT   = 4'd6,
        ALU_GE   = 4'd7,
        ALU_XOR  = 4'd8,
        ALU_SLL  = 4'd9,
        ALU_SRL  = 4'd10,
        ALU_SRA  = 4'd11,
        ALU_MUL  = 4'd12,
        ALU_MULH = 4'd13,
        ALU_DIV  = 4'd14,
        ALU_REM  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // True for the opcodes served by the iterative multiply/divide unit.
    function automatic logic is_muldiv(alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath. Works on operand magnitudes: shift-add
// multiply (one multiplier bit per cycle) and restoring division (one
// quotient bit per cycle), with the sign applied to the final value.
// 'done' and 'result' are valid combinationally in the last iteration cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    alu_op_e          op_e;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Control state.
    logic             active_q, active_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Datapath state. Multiply: {hi, lo} is the running product with the
    // multiplier in lo. Divide: hi is the partial remainder, lo the dividend
    // shifting out / quotient shifting in. mcand is |a| (mul) or |b| (div).
    logic             is_div_q, is_div_d;
    logic             sel_hi_q, sel_hi_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;

    logic [WIDTH:0]     sum, shifted, trial;
    logic [WIDTH-1:0]   addend;
    logic               ge;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   word;

    assign op_e  = alu_op_e'(op);
    assign a_neg = signed_mode & a[WIDTH-1];
    assign b_neg = signed_mode & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Operand load on start, one iteration per cycle while active.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        active_d = active_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        done     = 1'b0;

        addend  = lo_q[0] ? mcand_q : '0;
        sum     = {1'b0, hi_q} + {1'b0, addend};
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, mcand_q});
        trial   = shifted - {1'b0, mcand_q};

        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            is_div_d = (op_e == ALU_DIV) || (op_e == ALU_REM);
            sel_hi_d = (op_e == ALU_MULH) || (op_e == ALU_REM);
            hi_d     = '0;
            if ((op_e == ALU_DIV) || (op_e == ALU_REM)) begin
                lo_d    = a_mag;
                mcand_d = b_mag;
                // Remainder follows the dividend; a zero divisor keeps the
                // raw all-ones quotient unsigned.
                neg_d   = (op_e == ALU_REM) ? a_neg : ((a_neg ^ b_neg) & (b != '0));
            end else begin
                lo_d    = b_mag;
                mcand_d = a_mag;
                neg_d   = a_neg ^ b_neg;
            end
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
                hi_d = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ge};
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(WIDTH - 1)) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end
    end

    // Final sign fix-up and word select, taken from the last iteration.
    always_comb begin
        prod   = {hi_d, lo_d};
        prod_s = neg_q ? -prod : prod;
        word   = sel_hi_q ? hi_d : lo_d;
        if (is_div_q) begin
            result = neg_q ? -word : word;
        end else begin
            result = sel_hi_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
        end
    end

    // Control registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; every field is loaded on start before it is ever read.
        is_div_q <= is_div_d;
        sel_hi_q <= sel_hi_d;
        neg_q    <= neg_d;
        hi_q     <= hi_d;
        lo_q     <= lo_d;
        mcand_q  <= mcand_d;
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage. Single-cycle ops complete one cycle
// after acceptance; multiply/divide run WIDTH iterations in alu_muldiv_iter.
// The result is registered and held until the consumer takes it.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic             unsigned_flag,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             unknown_op,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    alu_op_e          op_e;
    logic             accept;
    logic             md_op;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] alu_res;
    logic [SW-1:0]    shamt;
    logic             lt;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             unknown_q, unknown_d;

    assign op_e   = alu_op_e'(alu_op);
    assign md_op  = is_muldiv(op_e);
    assign accept = in_valid & in_ready;
    assign shamt  = b[SW-1:0];
    assign lt     = unsigned_flag ? (a < b) : ($signed(a) < $signed(b));

    generate
        if (MULDIV_EN) begin : gen_muldiv
            logic md_start;
            assign md_start = accept & md_op;
            alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
                .clk         (clk),
                .reset_n     (reset_n),
                .start       (md_start),
                .op          (alu_op),
                .signed_mode (~unsigned_flag),
                .a           (a),
                .b           (b),
                .done        (md_done),
                .result      (md_result)
            );
        end else begin : gen_no_muldiv
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    // Single-cycle operations, evaluated on the operands presented at accept.
    always_comb begin
        alu_res = '0;
        case (op_e)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_ADD: alu_res = a + b;
            ALU_SUB: alu_res = a - b;
            ALU_EQ:  alu_res = WIDTH'(a == b);
            ALU_NE:  alu_res = WIDTH'(a != b);
            ALU_LT:  alu_res = WIDTH'(lt);
            ALU_GE:  alu_res = WIDTH'(!lt);
            ALU_XOR: alu_res = a ^ b;
            ALU_SLL: alu_res = a << shamt;
            ALU_SRL: alu_res = a >> shamt;
            ALU_SRA: alu_res = $unsigned($signed(a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // FSM next state and result capture.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        unknown_d = unknown_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (md_op && MULDIV_EN) begin
                        state_d   = BUSY;
                        unknown_d = 1'b0;
                    end else begin
                        state_d   = DONE;
                        result_d  = md_op ? '0 : alu_res;
                        unknown_d = md_op;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d  = DONE;
                    result_d = md_result;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            unknown_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            unknown_q <= unknown_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == BUSY);
    assign result     = result_q;
    assign zero       = (result_q == '0);
    assign unknown_op = unknown_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: one instance with multiply/divide enabled,
// one with it disabled. Expected results come from a behavioural model
// using native wide arithmetic and are queued when stimulus is driven.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid0, in_valid1;
    logic        out_ready;
    logic        unsigned_flag;
    logic [3:0]  alu_op;
    logic [31:0] a, b;

    logic        rdy0, ov0, z0, unk0, busy0;
    logic        rdy1, ov1, z1, unk1, busy1;
    logic [31:0] res0, res1;

    logic        sel = 1'b0;
    logic        o_ready, o_valid, o_zero, o_unk, o_busy;
    logic [31:0] o_res;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        unk;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(rdy0),
        .alu_op(alu_op), .unsigned_flag(unsigned_flag), .a(a), .b(b),
        .out_valid(ov0), .out_ready(out_ready), .result(res0), .zero(z0),
        .unknown_op(unk0), .busy(busy0)
    );

    alu_mc #(.WIDTH(32), .MULDIV_EN(1'b0)) dut_nomd (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(rdy1),
        .alu_op(alu_op), .unsigned_flag(unsigned_flag), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .result(res1), .zero(z1),
        .unknown_op(unk1), .busy(busy1)
    );

    assign o_ready = sel ? rdy1  : rdy0;
    assign o_valid = sel ? ov1   : ov0;
    assign o_res   = sel ? res1  : res0;
    assign o_zero  = sel ? z1    : z0;
    assign o_unk   = sel ? unk1  : unk0;
    assign o_busy  = sel ? busy1 : busy0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input bit uf,
                                   input logic [31:0] x, input logic [31:0] y, input bit md);
        exp_t        e;
        logic [63:0] pu;
        longint      ps;
        e.res = '0;
        e.unk = 1'b0;
        e.lat = 1;
        case (op)
            4'd0:  e.res = x & y;
            4'd1:  e.res = x | y;
            4'd2:  e.res = x + y;
            4'd3:  e.res = x - y;
            4'd4:  e.res = {31'b0, x == y};
            4'd5:  e.res = {31'b0, x != y};
            4'd6:  e.res = {31'b0, uf ? (x < y) : ($signed(x) < $signed(y))};
            4'd7:  e.res = {31'b0, uf ? (x >= y) : ($signed(x) >= $signed(y))};
            4'd8:  e.res = x ^ y;
            4'd9:  e.res = x << y[4:0];
            4'd10: e.res = x >> y[4:0];
            4'd11: e.res = $signed(x) >>> y[4:0];
            4'd12: e.res = x * y;
            4'd13: begin
                pu = {32'b0, x} * {32'b0, y};
                ps = longint'($signed(x)) * longint'($signed(y));
                e.res = uf ? pu[63:32] : ps[63:32];
            end
            4'd14: begin
                if (y == 0) e.res = 32'hFFFF_FFFF;
                else if (!uf && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) e.res = 32'h8000_0000;
                else if (uf) e.res = x / y;
                else e.res = $signed(x) / $signed(y);
            end
            default: begin
                if (y == 0) e.res = x;
                else if (!uf && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) e.res = 32'h0;
                else if (uf) e.res = x % y;
                else e.res = $signed(x) % $signed(y);
            end
        endcase
        if (op >= 4'd12) begin
            if (md) begin
                e.lat = 33;
            end else begin
                e.res = '0;
                e.unk = 1'b1;
            end
        end
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Issue one request, wait (bounded) for the result, optionally hold it
    // for 'hold' cycles while a competing request is presented, then consume.
    task automatic run_op(input bit s, input logic [3:0] op, input bit uf,
                          input logic [31:0] av, input logic [31:0] bv, input int hold);
        exp_t e;
        int   lat;
        sel = s;
        sb.push_back(model(op, uf, av, bv, !s));
        @(negedge clk);
        check("in_ready_pre", o_ready, 1);
        alu_op = op; unsigned_flag = uf; a = av; b = bv;
        if (s) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        lat = 1;
        check("busy_first", o_busy, sb[0].lat > 1);
        while (!o_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!o_valid) begin
            check("timeout", 0, 1);
            return;
        end
        check($sformatf("latency op%0d", op), lat, e.lat);
        check($sformatf("result op%0d a=%0h b=%0h", op, av, bv), o_res, e.res);
        check($sformatf("zero op%0d", op), o_zero, e.zero);
        check($sformatf("unknown op%0d", op), o_unk, e.unk);
        for (int i = 0; i < hold; i++) begin
            alu_op = 4'd2; a = 32'd1; b = 32'd1;
            if (s) in_valid1 = 1'b1; else in_valid0 = 1'b1;
            @(negedge clk);
            check("hold_valid", o_valid, 1);
            check("hold_result", o_res, e.res);
            check("hold_zero", o_zero, e.zero);
        end
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed", o_valid, 0);
        check("in_ready_post", o_ready, 1);
    endtask

    initial begin
        reset_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
        unsigned_flag = 1'b0; alu_op = 4'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", ov0, 0);
        check("rst_result", res0, 0);
        check("rst_zero", z0, 1);
        check("rst_unknown", unk0, 0);
        check("rst_busy", busy0, 0);
        check("rst_nomd_out_valid", ov1, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", rdy0, 1);

        run_op(0, 4'd2, 0, 32'd5, 32'd7, 0);
        run_op(0, 4'd3, 0, 32'd3, 32'd3, 4);
        run_op(0, 4'd6, 0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(0, 4'd6, 1, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(0, 4'd11, 0, 32'h8000_0000, 32'h24, 0);
        run_op(0, 4'd12, 0, 32'd7, -32'sd6, 0);
        run_op(0, 4'd13, 0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(0, 4'd13, 1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(0, 4'd14, 0, -32'sd7, 32'd2, 0);
        run_op(0, 4'd15, 0, -32'sd7, 32'd2, 0);
        run_op(0, 4'd14, 0, 32'h1234_5678, 32'd0, 0);
        run_op(0, 4'd15, 0, 32'h8765_4321, 32'd0, 0);
        run_op(0, 4'd14, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, 4'd15, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, 4'd13, 0, -32'sd3, 32'd5, 0);
        run_op(0, 4'd15, 1, 32'hFFFF_FFF9, 32'd10, 0);

        // Directed single-cycle ops, then a short random sweep of all opcodes.
        run_op(0, 4'd0, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run_op(0, 4'd1, 0, 32'hF000_0000, 32'h0000_000F, 0);
        run_op(0, 4'd4, 0, 32'hABCD, 32'hABCD, 0);
        run_op(0, 4'd5, 0, 32'hABCD, 32'hABCD, 0);
        run_op(0, 4'd7, 0, 32'h8000_0000, 32'd0, 0);
        run_op(0, 4'd8, 0, 32'hFFFF_0000, 32'h0F0F_0F0F, 0);
        run_op(0, 4'd9, 0, 32'h0000_0001, 32'd31, 0);
        run_op(0, 4'd10, 0, 32'h8000_0000, 32'd31, 0);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            run_op(0, 4'(i), $urandom_range(0, 1) == 1, ra, rb, 0);
        end

        // Multiply/divide disabled: unknown op, single-cycle latency.
        run_op(1, 4'd14, 0, 32'd100, 32'd7, 0);
        run_op(1, 4'd2, 0, 32'hFFFF_FFFF, 32'd1, 0);

        // Reset in the middle of a divide discards it.
        sel = 1'b0;
        @(negedge clk);
        alu_op = 4'd14; unsigned_flag = 1'b0; a = 32'd100; b = 32'd3; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", busy0, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", ov0, 0);
        check("abort_busy", busy0, 0);
        check("abort_in_ready", rdy0, 1);
        check("abort_result", res0, 0);
        check("abort_zero", z0, 1);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_result", ov0, 0);
        run_op(0, 4'd14, 0, 32'd100, 32'd3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
